// File: rtl/uart_pkg.sv
// Purpose : constants shared by the UART receiver and transmitter.
// Latency : n/a (declarations only).
// Backpressure: n/a.
//
// Contents: OVERSAMPLE (s_tick pulses per bit period) and the FSM state encoding.
package uart_pkg;

   localparam int OVERSAMPLE = 16;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4
   } uart_state_t;

endpackage

// File: rtl/uart_rx_sync.sv
// Purpose : two-flop synchronizer bringing the asynchronous serial line into clk.
// Latency : 2 clk from d to q.
// Backpressure: none; free-running.
//
// Ports: clk, rst_n (async active-low, flops reset to 1 = line idle), d (async in), q (synced out).
module uart_rx_sync (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q
);

   logic meta;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta <= 1'b1;
         q    <= 1'b1;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/uart_rx.sv
// Purpose : UART receiver, 16x oversampled, DBIT data bits LSB first, optional even parity.
// Latency : rx_done_tick one clk after the final stop-bit s_tick (plus 2 clk input sync).
// Backpressure: none; dout holds until the next frame completes, consumer must keep up.
//
// Ports: clk, rst_n (async active-low), s_tick (16 per bit), rx (async serial, idle high),
//        dout[7:0] (right-justified data), rx_done_tick, frame_err, parity_err (one-clk pulses).
// Build option: define UART_RX_PARITY_EN to add a parity bit after the data bits;
//        otherwise parity_err is tied to 0.
module uart_rx
   import uart_pkg::*;
#(
   parameter int DBIT    = 8,
   parameter int SB_TICK = 16
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       s_tick,
   input  logic       rx,
   output logic [7:0] dout,
   output logic       rx_done_tick,
   output logic       frame_err,
   output logic       parity_err
);

   // The tick counter only needs to grow past 4 bits for 1.5/2 stop bits (SB_TICK 24/32).
   localparam int SW = (SB_TICK > OVERSAMPLE) ? $clog2(SB_TICK) : 4;

   localparam logic [SW-1:0] S_MID  = SW'(OVERSAMPLE / 2 - 1);
   localparam logic [SW-1:0] S_LAST = SW'(OVERSAMPLE - 1);
   localparam logic [SW-1:0] S_STOP = SW'(SB_TICK - 1);
   localparam logic [2:0]    N_LAST = 3'(DBIT - 1);

   uart_state_t   state;
   logic [SW-1:0] s;
   logic [2:0]    n;
   logic [7:0]    b;
   logic          line;

`ifdef UART_RX_PARITY_EN
   logic          par_bit;
`endif

   uart_rx_sync u_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .d     (rx),
      .q     (line)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= IDLE;
         s            <= '0;
         n            <= '0;
         b            <= '0;
         dout         <= '0;
         rx_done_tick <= 1'b0;
         frame_err    <= 1'b0;
`ifdef UART_RX_PARITY_EN
         par_bit      <= 1'b0;
         parity_err   <= 1'b0;
`endif
      end else begin
         rx_done_tick <= 1'b0;
         frame_err    <= 1'b0;
`ifdef UART_RX_PARITY_EN
         parity_err   <= 1'b0;
`endif
         case (state)
            // Falling edge seen: no s_tick needed, so a start bit right after
            // the previous stop sample is caught in the next cycle.
            IDLE: begin
               if (!line) begin
                  state <= START;
                  s     <= '0;
               end
            end
            // Re-check the line at mid start bit; a high line there was a glitch.
            START: begin
               if (s_tick) begin
                  if (s == S_MID) begin
                     if (!line) begin
                        state <= DATA;
                        s     <= '0;
                        n     <= '0;
                     end else begin
                        state <= IDLE;
                     end
                  end else begin
                     s <= s + 1'b1;
                  end
               end
            end
            // Sample each data bit at its centre; LSB arrives first so shift right.
            DATA: begin
               if (s_tick) begin
                  if (s == S_LAST) begin
                     s <= '0;
                     b <= {line, b[7:1]};
                     if (n == N_LAST) begin
`ifdef UART_RX_PARITY_EN
                        state <= PARITY;
`else
                        state <= STOP;
`endif
                     end else begin
                        n <= n + 1'b1;
                     end
                  end else begin
                     s <= s + 1'b1;
                  end
               end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
               if (s_tick) begin
                  if (s == S_LAST) begin
                     s       <= '0;
                     par_bit <= line;
                     state   <= STOP;
                  end else begin
                     s <= s + 1'b1;
                  end
               end
            end
`endif
            // Data is published even on a bad stop bit; frame_err flags it.
            STOP: begin
               if (s_tick) begin
                  if (s == S_STOP) begin
                     state        <= IDLE;
                     s            <= '0;
                     rx_done_tick <= 1'b1;
                     frame_err    <= ~line;
                     // For DBIT < 8 the data sits in the top of b; move it down.
                     dout         <= b >> (8 - DBIT);
`ifdef UART_RX_PARITY_EN
                     // Even parity: data bits plus parity bit must XOR to 0.
                     parity_err   <= (^(b >> (8 - DBIT))) ^ par_bit;
`endif
                  end else begin
                     s <= s + 1'b1;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifndef UART_RX_PARITY_EN
   assign parity_err = 1'b0;
`endif

endmodule
